// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scan-code decoder: folds E0/F0/E1 prefix sequences into single
// {ext, brk, code} key events and queues them in a small show-ahead FIFO.
module ps2_key_decoder #(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] din,
  output logic       rx_en,
  input  logic       rd_en,
  output logic [9:0] key_out,
  output logic       key_empty,
  output logic       key_full,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXT  = 2'd1;
  localparam logic [1:0] S_BRK  = 2'd2;
  localparam logic [1:0] S_SKIP = 2'd3;

  localparam logic [7:0] B_EXT   = 8'hE0;
  localparam logic [7:0] B_BRK   = 8'hF0;
  localparam logic [7:0] B_PAUSE = 8'hE1;

  logic [1:0]    state_q, state_d;
  logic          ext_q, ext_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          timeout;

  logic          push;
  logic [9:0]    push_data;

  logic [9:0]    mem_q [DEPTH];
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic          ovf_q, ovf_d;
  logic          pop;
  logic          do_push;

  // Keyboard-controller responses (ack, BAT result, echo, errors) are not keys.
  function automatic logic is_response(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA,
      8'hFC, 8'hFD, 8'hFE, 8'hFF: is_response = 1'b1;
      default:                    is_response = 1'b0;
    endcase
  endfunction

  // A byte arriving in the timeout cycle wins, so timeout requires no strobe.
  assign timeout = (state_q != S_IDLE) && !rx_done_tick && (tmo_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    ext_d     = ext_q;
    skip_d    = skip_q;
    push      = 1'b0;
    push_data = 10'h000;

    if (rx_done_tick || state_q == S_IDLE || timeout) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    if (rx_done_tick) begin
      case (state_q)
        S_IDLE: begin
          if (din == B_EXT) begin
            state_d = S_EXT;
            ext_d   = 1'b1;
          end else if (din == B_BRK) begin
            state_d = S_BRK;
            ext_d   = 1'b0;
          end else if (din == B_PAUSE) begin
            state_d = S_SKIP;
            skip_d  = 3'd7;
          end else if (!is_response(din)) begin
            push      = 1'b1;
            push_data = {2'b00, din};
          end
        end
        S_EXT: begin
          if (din == B_BRK) begin
            state_d = S_BRK;
          end else if (din != B_EXT) begin
            push      = 1'b1;
            push_data = {2'b10, din};
            state_d   = S_IDLE;
            ext_d     = 1'b0;
          end
        end
        S_BRK: begin
          push      = 1'b1;
          push_data = {ext_q, 1'b1, din};
          state_d   = S_IDLE;
          ext_d     = 1'b0;
        end
        default: begin
          // Remaining pause-sequence bytes are swallowed without an event.
          if (skip_q <= 3'd1) begin
            skip_d  = 3'd0;
            state_d = S_IDLE;
          end else begin
            skip_d = skip_q - 3'd1;
          end
        end
      endcase
    end else if (timeout) begin
      state_d = S_IDLE;
      ext_d   = 1'b0;
      skip_d  = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ext_q   <= 1'b0;
      skip_q  <= 3'd0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      ext_q   <= ext_d;
      skip_q  <= skip_d;
      tmo_q   <= tmo_d;
    end
  end

  // Extra wrap bit on each pointer distinguishes full from empty.
  assign key_empty = (wr_q == rd_q);
  assign key_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rx_en     = ~key_full;
  assign overflow  = ovf_q;
  assign key_out   = key_empty ? 10'h000 : mem_q[rd_q[AW-1:0]];

  assign pop     = rd_en && !key_empty;
  assign do_push = push && (!key_full || pop);
  assign wr_d    = wr_q + (AW+1)'(do_push);
  assign rd_d    = rd_q + (AW+1)'(pop);
  assign ovf_d   = ovf_q | (push && key_full && !pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: prefix decoding, timeout, pause
// swallowing, FIFO full/overflow handling and asynchronous reset.
module tb_ps2_key_decoder;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic       clk;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] din;
  logic       rx_en;
  logic       rd_en;
  logic [9:0] key_out;
  logic       key_empty;
  logic       key_full;
  logic       overflow;

  int vecCount  = 0;
  int missCount = 0;

  ps2_key_decoder #(
    .DEPTH       (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .din          (din),
    .rx_en        (rx_en),
    .rd_en        (rd_en),
    .key_out      (key_out),
    .key_empty    (key_empty),
    .key_full     (key_full),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the strobe is sampled by the next rising edge.
  task automatic applyStimulus(input logic [7:0] b, input logic rd);
    rx_done_tick = 1'b1;
    din          = b;
    rd_en        = rd;
    @(negedge clk);
    rx_done_tick = 1'b0;
    rd_en        = 1'b0;
  endtask

  task automatic popKey(input string tag, input logic [9:0] exp);
    checkOutput(tag, 32'(key_out), 32'(exp));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  logic [7:0] pauseSeq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  initial begin
    reset        = 1'b0;
    rx_done_tick = 1'b0;
    din          = 8'h00;
    rd_en        = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_empty", 32'(key_empty), 32'd1);
    checkOutput("rst_full", 32'(key_full), 32'd0);
    checkOutput("rst_rx_en", 32'(rx_en), 32'd1);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    checkOutput("rst_key_out", 32'(key_out), 32'h000);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] make / break of 1C");
    applyStimulus(8'h1C, 1'b0);
    checkOutput("make_latency_empty", 32'(key_empty), 32'd0);
    checkOutput("make_latency_key", 32'(key_out), 32'h01C);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h1C, 1'b0);
    popKey("make_1C", 10'h01C);
    popKey("break_1C", 10'h11C);
    checkOutput("t1_empty", 32'(key_empty), 32'd1);

    $display("[TB] extended codes and responses");
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'h75, 1'b0);
    popKey("ext_make_75", 10'h275);
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h75, 1'b0);
    popKey("ext_break_75", 10'h375);
    applyStimulus(8'hFA, 1'b0);
    applyStimulus(8'hAA, 1'b0);
    applyStimulus(8'h00, 1'b0);
    checkOutput("responses_dropped", 32'(key_empty), 32'd1);

    $display("[TB] prefix timeout");
    applyStimulus(8'hE0, 1'b0);
    repeat (TMO) @(negedge clk);
    applyStimulus(8'h1C, 1'b0);
    popKey("after_timeout", 10'h01C);
    checkOutput("after_timeout_single", 32'(key_empty), 32'd1);
    applyStimulus(8'hE0, 1'b0);
    repeat (TMO - 1) @(negedge clk);
    applyStimulus(8'h1C, 1'b0);
    popKey("byte_beats_timeout", 10'h21C);
    checkOutput("byte_beats_timeout_single", 32'(key_empty), 32'd1);

    $display("[TB] pause sequence");
    for (int i = 0; i < 8; i++) applyStimulus(pauseSeq[i], 1'b0);
    checkOutput("pause_no_event", 32'(key_empty), 32'd1);
    applyStimulus(8'h1C, 1'b0);
    popKey("after_pause", 10'h01C);
    checkOutput("after_pause_single", 32'(key_empty), 32'd1);

    $display("[TB] FIFO full and overflow");
    applyStimulus(8'h15, 1'b0);
    applyStimulus(8'h1D, 1'b0);
    applyStimulus(8'h24, 1'b0);
    checkOutput("three_not_full", 32'(key_full), 32'd0);
    applyStimulus(8'h2D, 1'b0);
    checkOutput("four_full", 32'(key_full), 32'd1);
    checkOutput("four_rx_en", 32'(rx_en), 32'd0);
    checkOutput("four_ovf", 32'(overflow), 32'd0);
    applyStimulus(8'h2C, 1'b1);
    checkOutput("push_pop_full_ovf", 32'(overflow), 32'd0);
    checkOutput("push_pop_full_cnt", 32'(key_full), 32'd1);
    checkOutput("push_pop_full_head", 32'(key_out), 32'h01D);
    applyStimulus(8'h35, 1'b0);
    checkOutput("drop_ovf", 32'(overflow), 32'd1);
    checkOutput("drop_full", 32'(key_full), 32'd1);
    popKey("rd0", 10'h01D);
    popKey("rd1", 10'h024);
    popKey("rd2", 10'h02D);
    popKey("rd3", 10'h02C);
    checkOutput("drained_empty", 32'(key_empty), 32'd1);
    checkOutput("drained_rx_en", 32'(rx_en), 32'd1);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);
    applyStimulus(8'h1C, 1'b1);
    checkOutput("push_pop_empty", 32'(key_empty), 32'd0);
    popKey("push_pop_empty_key", 10'h01C);
    checkOutput("push_pop_empty_one", 32'(key_empty), 32'd1);

    $display("[TB] async reset mid-sequence");
    applyStimulus(8'h15, 1'b0);
    applyStimulus(8'h1D, 1'b0);
    applyStimulus(8'h24, 1'b0);
    applyStimulus(8'hE0, 1'b0);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_empty", 32'(key_empty), 32'd1);
    checkOutput("async_ovf", 32'(overflow), 32'd0);
    checkOutput("async_rx_en", 32'(rx_en), 32'd1);
    checkOutput("async_key_out", 32'(key_out), 32'h000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(8'h75, 1'b0);
    popKey("post_reset_75", 10'h075);
    checkOutput("post_reset_single", 32'(key_empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Downstream stage of the PS/2 receiver. It consumes the receiver's byte strobe and data byte and assembles PS/2 Set-2 scan-code sequences (E0 extended prefix, F0 break prefix, E1 pause sequence) into single key events. Each event carries an extended flag, a break flag and the 8-bit code, and is buffered in a small show-ahead FIFO for the keyboard application logic. It drives the receiver's rx_en so that bytes are not accepted while the FIFO is full.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16.
TIMEOUT_CYC, 2500000, idle clock cycles (50 ms at 50 MHz) after which a partial prefix sequence is abandoned.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low; reset==0 clears all state immediately
rx_done_tick  in  1  one-cycle strobe from the receiver: din is valid
din  in  8  received scan-code byte
rx_en  out  1  receiver enable; equals ~key_full
rd_en  in  1  pop the head event; ignored when key_empty
key_out  out  10  head event {ext, brk, code[7:0]}; valid when key_empty==0
key_empty  out  1  FIFO empty
key_full  out  1  FIFO holds DEPTH events
overflow  out  1  sticky; set when an event is dropped, cleared only by reset

Behaviour:
- Reset (reset==0, async): state=IDLE, ext/brk flags=0, skip count=0, timeout counter=0, FIFO empty. Outputs: key_empty=1, key_full=0, rx_en=1, overflow=0, key_out=0.
- The FSM advances only on cycles with rx_done_tick==1. Otherwise it holds, except for a timeout.
- States and transitions, for a byte b:
  - IDLE:
    - b==E0: go to EXT, ext=1.
    - b==F0: go to BRK, ext=0.
    - b==E1: go to SKIP, skip=7.
    - b in {00, AA, EE, FA, FC, FD, FE, FF}: discard (controller/ack responses); stay in IDLE.
    - Any other b: push {0,0,b}; stay in IDLE.
  - EXT:
    - b==F0: go to BRK, ext stays 1.
    - b==E0: stay in EXT.
    - Else: push {1,0,b}, go to IDLE, clear ext.
  - BRK: push {ext,1,b}, go to IDLE, clear ext (any b, including F0/E0).
  - SKIP: skip=skip-1; at skip==1→0 go to IDLE. Nothing is pushed, so the pause key generates no event.
- Timeout:
  - A counter clears on every rx_done_tick and increments each cycle while state!=IDLE.
  - When it reaches TIMEOUT_CYC-1: go to IDLE, clear ext/skip, push nothing, clear the counter.
  - A byte arriving in the same cycle as the timeout takes priority; the timeout is ignored.
  - The counter is held at 0 in IDLE.
- Latency: a push decided in cycle N is visible as key_empty=0 and key_out valid in cycle N+1.
- FIFO:
  - Show-ahead: key_out is combinational from the head entry.
  - rd_en with key_empty=0 advances the head at the clock edge.
  - Push when not full: write the tail.
  - Push and rd_en in the same cycle while full: both happen, the count is unchanged, and overflow is not set.
  - Push while full without rd_en: the event is dropped and overflow is set to 1.
  - Push and rd_en in the same cycle while empty: the push happens, the pop is ignored, and the count becomes 1.
  - Pointers are log2(DEPTH) bits with an extra wrap bit, and wrap modulo DEPTH.
- rx_en=~key_full is combinational. The receiver samples it only at a start bit, so a byte already in flight may still arrive while full and is handled by the overflow rule.
- Reset mid-sequence (e.g. after E0 and before the final byte) discards the partial sequence. The next byte is decoded from IDLE.

Test Plan:
1. Bytes 1C; F0 1C, no reads → key_out 0x01C, then after rd_en 0x11C. key_empty=1 after the second rd_en. Push visible exactly 1 cycle after the strobe.
2. Bytes E0 75; E0 F0 75 → events 0x275 then 0x375. Also bytes FA, AA → no events, key_empty stays 1.
3. E0, then no strobe for TIMEOUT_CYC cycles (use TIMEOUT_CYC=16), then 1C → single event 0x01C, not 0x21C. Repeat with 1C arriving in the same cycle as the timeout → 0x21C.
4. Pause sequence E1 14 77 E1 F0 14 F0 77, then 1C → exactly one event, 0x01C.
5. DEPTH=4: 5 make codes 15,1D,24,2D,2C, no reads:
   - key_full=1 and rx_en=0 after the 4th; overflow=1 after the 5th.
   - Reads return 015,01D,024,02D in order.
   - Then a push with simultaneous rd_en while full → overflow unchanged, count stays 4.
6. Async reset asserted between E0 and 75, and mid-clock with 3 entries queued:
   - Immediate key_empty=1, overflow=0, rx_en=1.
   - After release, byte 75 → 0x075.
